lsu_mem: RTL

LSU_MEM -- requirements
Module: lsu_mem

---
 rtl/pipeline_pkg.sv | 79 +++++++
 rtl/lsu_mem_if.sv | 23 ++
 rtl/lsu_load_align.sv | 27 ++
 rtl/lsu_mem.sv | 90 +++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared LSU types: FSM state encoding, RV32I load/store funct3 codes, latched request
// payload, and the store-lane/legality helpers used by the memory stage.
package pipeline_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned F3_W   = 3;

    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;
    localparam logic [F3_W-1:0] F3_SB  = 3'b000;
    localparam logic [F3_W-1:0] F3_SH  = 3'b001;
    localparam logic [F3_W-1:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [F3_W-1:0] funct3;
        logic            write;
    } lsu_req_t;

    // Known width code with natural alignment for that width.
    function automatic logic access_legal(input logic write, input logic [F3_W-1:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (write) begin
            case (f3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = ~off[0];
                F3_SW:   ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = ~off[0];
                F3_LW:         ok = (off == 2'b00);
                default:       ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [STRB_W-1:0] store_strb(input logic [F3_W-1:0] f3,
                                                     input logic [1:0] off);
        logic [STRB_W-1:0] strb;
        case (f3)
            F3_SB:   strb = STRB_W'(1) << off;
            F3_SH:   strb = STRB_W'(3) << {off[1], 1'b0};
            F3_SW:   strb = {STRB_W{1'b1}};
            default: strb = '0;
        endcase
        return strb;
    endfunction

    // Narrow stores are replicated across every lane so the strobe alone picks the bytes.
    function automatic logic [XLEN-1:0] store_data(input logic [F3_W-1:0] f3,
                                                   input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] data;
        case (f3)
            F3_SB:   data = {(XLEN/8){wd[7:0]}};
            F3_SH:   data = {(XLEN/16){wd[15:0]}};
            default: data = wd;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Word-addressed memory bus between the LSU (master) and the data memory (slave).
interface lsu_mem_if;
    import pipeline_pkg::*;

    logic              bus_req;
    logic              bus_we;
    logic [XLEN-1:0]   bus_addr;
    logic [STRB_W-1:0] bus_wstrb;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [XLEN-1:0]   bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module lsu_load_align
    import pipeline_pkg::*;
(
    input  logic [F3_W-1:0] funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata >> {offset, 3'b000});
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// MEM-stage load/store unit: turns one pipeline load/store into a single bus
// transaction, stalling the pipe until it completes or faulting illegal accesses.
module lsu_mem
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    input  logic            op_write,
    input  logic [F3_W-1:0] funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    lsu_mem_if.master       mem,
    output logic [XLEN-1:0] load_data,
    output logic            done,
    output logic            stall,
    output logic            fault
);

    lsu_state_t      state;
    lsu_state_t      state_next;
    lsu_req_t        req_q;
    logic            op_legal;
    logic            accept;
    logic [XLEN-1:0] align_data;

    assign op_legal = access_legal(op_write, funct3, addr[1:0]);
    assign accept   = (state == IDLE) && op_valid && op_legal;

    lsu_load_align u_align (
        .funct3 (req_q.funct3),
        .offset (req_q.addr[1:0]),
        .rdata  (mem.bus_rdata),
        .data   (align_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)         state_next = REQ;
            REQ:  if (mem.bus_gnt)    state_next = req_q.write ? DONE : WAIT;
            WAIT: if (mem.bus_rvalid) state_next = DONE;
            DONE:                     state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Bus fields only carry the latched request while it is being offered.
    always_comb begin
        mem.bus_req   = 1'b0;
        mem.bus_we    = 1'b0;
        mem.bus_addr  = '0;
        mem.bus_wstrb = '0;
        mem.bus_wdata = '0;
        fault         = (state == IDLE) && op_valid && !op_legal;
        done          = (state == DONE);
        stall         = op_valid && !fault && (state != DONE);
        if (state == REQ) begin
            mem.bus_req   = 1'b1;
            mem.bus_we    = req_q.write;
            mem.bus_addr  = {req_q.addr[XLEN-1:2], 2'b00};
            mem.bus_wstrb = req_q.write ? store_strb(req_q.funct3, req_q.addr[1:0]) : '0;
            mem.bus_wdata = req_q.write ? store_data(req_q.funct3, req_q.wdata) : '0;
        end
    end

    // Request snapshot and load result; load_data only moves when a load completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= '0;
            load_data <= '0;
        end else begin
            if (accept) begin
                req_q <= '{addr: addr, wdata: wdata, funct3: funct3, write: op_write};
            end
            if ((state == WAIT) && mem.bus_rvalid) begin
                load_data <= align_data;
            end
        end
    end

endmodule
